// File: rtl/uart_pkg.sv
// uart_pkg: constants, FSM encoding and helpers shared by the UART transmitter and receiver.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   function automatic int calc_bit_cycles(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; bit_end marks the last clock of each bit time.
module uart_baud_gen #(
   parameter int BIT_CYCLES = 5208
) (
   input  logic sys_clk,
   input  logic sys_rstn,
   input  logic clr,
   input  logic en,
   output logic bit_end
);

   localparam int W = $clog2(BIT_CYCLES);

   logic [W-1:0] cnt;

   assign bit_end = (cnt == W'(BIT_CYCLES - 1));

   always_ff @(posedge sys_clk or negedge sys_rstn)
      if (!sys_rstn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= bit_end ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input, optional parity
// and one or two stop bits; frames are sent back-to-back while tx_valid stays high.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int UART_BAUD_RATE = 9600,
   parameter int CLK_FREQ       = 50_000_000,
   parameter int DATA_BITS      = 8,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rstn,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, UART_BAUD_RATE);

   if (BIT_CYCLES < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("uart_tx_frame: illegal parameter set");
   end

   uart_state_e          state, state_d;
   logic [DATA_BITS-1:0] shift, shift_d;
   logic [2:0]           bit_idx, bit_idx_d;
   logic                 stop_idx, stop_idx_d;
   logic                 par, par_d;
   logic                 tx_d, done_d, bit_end, accept;

   assign tx_ready = (state == ST_IDLE);
   assign tx_busy  = ~tx_ready;
   assign accept   = tx_valid & tx_ready;

   uart_baud_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
      .sys_clk (sys_clk),
      .sys_rstn(sys_rstn),
      .clr     (state_d != state),
      .en      (tx_busy),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d    = state;
      shift_d    = shift;
      bit_idx_d  = bit_idx;
      stop_idx_d = stop_idx;
      par_d      = par;
      done_d     = 1'b0;
      case (state)
         ST_IDLE:
            if (accept) begin
               state_d    = ST_START;
               shift_d    = tx_data;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               par_d      = (PARITY == PAR_EVEN) ? ^tx_data : ~^tx_data;
            end
         ST_START:
            if (bit_end) state_d = ST_DATA;
         ST_DATA:
            if (bit_end) begin
               shift_d   = shift >> 1;
               bit_idx_d = bit_idx + 3'd1;
               if (bit_idx == 3'(DATA_BITS - 1))
                  state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
         ST_PARITY:
            if (bit_end) state_d = ST_STOP;
         ST_STOP:
            if (bit_end) begin
               stop_idx_d = 1'b1;
               if (stop_idx == 1'(STOP_BITS - 1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         default: state_d = ST_IDLE;
      endcase
      // tx is registered from the next state so the line changes on the same edge as the FSM
      tx_d = (state_d == ST_DATA)   ? shift_d[0] :
             (state_d == ST_PARITY) ? par        : (state_d != ST_START);
   end

   always_ff @(posedge sys_clk or negedge sys_rstn)
      if (!sys_rstn) begin
         state    <= ST_IDLE;
         shift    <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         par      <= 1'b0;
         tx       <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_d;
         shift    <= shift_d;
         bit_idx  <= bit_idx_d;
         stop_idx <= stop_idx_d;
         par      <= par_d;
         tx       <= tx_d;
         tx_done  <= done_d;
      end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four transmitter configurations (8N1 default, 8E2, 8O1, 5N1) checked
// against a frame model through a scoreboard fed by a mid-bit line decoder.
module tb_uart_tx_frame;

   logic clk = 1'b0;
   logic sys_rstn;
   always #5 clk = ~clk;

   logic [3:0] vld;
   logic [7:0] dat [4];
   wire  [3:0] rdy, txl, bsy, dn;

   int errors = 0, checks = 0, frames = 0, cyc = 0, mon_sel = 0;
   bit abort = 1'b0;
   logic [11:0] sb [$];

   int bc_t  [4] = '{5208, 4, 4, 4};
   int db_t  [4] = '{8, 8, 8, 5};
   int par_t [4] = '{0, 2, 1, 0};
   int st_t  [4] = '{1, 2, 1, 1};

   uart_tx_frame u_def (
      .sys_clk(clk), .sys_rstn(sys_rstn), .tx_valid(vld[0]), .tx_data(dat[0]),
      .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
   uart_tx_frame #(.UART_BAUD_RATE(10), .CLK_FREQ(40), .PARITY(2), .STOP_BITS(2)) u_e2 (
      .sys_clk(clk), .sys_rstn(sys_rstn), .tx_valid(vld[1]), .tx_data(dat[1]),
      .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
   uart_tx_frame #(.UART_BAUD_RATE(10), .CLK_FREQ(40), .PARITY(1)) u_o1 (
      .sys_clk(clk), .sys_rstn(sys_rstn), .tx_valid(vld[2]), .tx_data(dat[2]),
      .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
   uart_tx_frame #(.UART_BAUD_RATE(10), .CLK_FREQ(40), .DATA_BITS(5)) u_d5 (
      .sys_clk(clk), .sys_rstn(sys_rstn), .tx_valid(vld[3]), .tx_data(dat[3][4:0]),
      .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int len_of(input int s);
      return 1 + db_t[s] + (par_t[s] != 0 ? 1 : 0) + st_t[s];
   endfunction

   // Expected line bits, index 0 = start bit; unused upper bits stay 1.
   function automatic logic [11:0] frame_of(input int s, input logic [7:0] d);
      logic [11:0] f = '1;
      int n = 1;
      logic p = 1'b0;
      f[0] = 1'b0;
      for (int i = 0; i < db_t[s]; i++) begin
         f[n] = d[i];
         p ^= d[i];
         n++;
      end
      if (par_t[s] != 0) f[n] = (par_t[s] == 2) ? p : ~p;
      return f;
   endfunction

   wire tx_m = txl[mon_sel];

   // Decoder: samples the selected line at each bit centre and checks against the scoreboard.
   always begin
      logic [11:0] got;
      logic [11:0] e;
      int b, l;
      @(negedge tx_m);
      b = bc_t[mon_sel];
      l = len_of(mon_sel);
      got = '1;
      repeat (b / 2) @(posedge clk);
      for (int i = 0; i < l; i++) begin
         if (i > 0) repeat (b) @(posedge clk);
         #1 got[i] = tx_m;
      end
      frames++;
      if (abort) begin
         abort = 1'b0;
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: decoded %b, expected no frame", got);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL frame_bits: decoded %b, expected %b", got, e);
            end
         end
      end
   end

   task automatic send(input int s, input logic [7:0] d, output int lat);
      int n = 0;
      mon_sel = s;
      sb.push_back(frame_of(s, d));
      @(negedge clk);
      vld[s] = 1'b1;
      dat[s] = d;
      while (!rdy[s] && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 vld[s] = 1'b0;
      n = 0;
      while (!dn[s] && n < 60000) begin
         @(posedge clk);
         #1 n++;
      end
      lat = n;
   endtask

   task automatic test_reset;
      sys_rstn = 1'b0;
      vld = '0;
      for (int i = 0; i < 4; i++) dat[i] = '0;
      #23;
      checks++; if (txl !== 4'hF) begin errors++; $display("FAIL reset_tx: got %b, expected 1111", txl); end
      checks++; if (rdy !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b, expected 1111", rdy); end
      checks++; if (bsy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b, expected 0000", bsy); end
      checks++; if (dn !== 4'h0) begin errors++; $display("FAIL reset_done: got %b, expected 0000", dn); end
      @(negedge clk) sys_rstn = 1'b1;
   endtask

   task automatic test_default;
      int b = bc_t[0];
      int done_k = -1;
      logic [11:0] f = frame_of(0, 8'hA5);
      mon_sel = 0;
      sb.push_back(f);
      @(negedge clk);
      vld[0] = 1'b1;
      dat[0] = 8'hA5;
      checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL default_ready: got %b, expected 1", rdy[0]); end
      @(posedge clk);
      #1 vld[0] = 1'b0;
      for (int k = 0; k <= 10 * b; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (dn[0] && done_k < 0) done_k = k;
         if (k == 1) begin
            checks++;
            if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
               errors++;
               $display("FAIL default_busy: busy=%b ready=%b, expected busy=1 ready=0", bsy[0], rdy[0]);
            end
         end
         if (k < 10 * b && (k % b == 0 || k % b == b - 1)) begin
            checks++;
            if (txl[0] !== f[k / b]) begin
               errors++;
               $display("FAIL default_bit%0d_cycle%0d: tx=%b, expected %b", k / b, k % b, txl[0], f[k / b]);
            end
         end
      end
      checks++; if (done_k != 10 * b) begin errors++; $display("FAIL default_done_latency: got %0d, expected %0d", done_k, 10 * b); end
      @(posedge clk);
      #1;
      checks++; if (dn[0] !== 1'b0) begin errors++; $display("FAIL default_done_width: tx_done=%b one cycle later, expected 0", dn[0]); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL default_scoreboard: %0d frames pending, expected 0", sb.size()); end
   endtask

   task automatic test_parity;
      int lat;
      send(1, 8'h07, lat);
      checks++; if (lat != 48) begin errors++; $display("FAIL even2_latency: got %0d, expected 48", lat); end
      send(2, 8'h07, lat);
      checks++; if (lat != 44) begin errors++; $display("FAIL odd1_latency: got %0d, expected 44", lat); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL parity_scoreboard: %0d pending, expected 0", sb.size()); end
   endtask

   task automatic test_data5;
      int lat;
      send(3, 8'hFF, lat);
      checks++; if (lat != 28) begin errors++; $display("FAIL data5_latency: got %0d, expected 28", lat); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL data5_scoreboard: %0d pending, expected 0", sb.size()); end
   endtask

   task automatic test_back_to_back;
      int t_prev = 0, n, f0 = frames;
      mon_sel = 2;
      sb.push_back(frame_of(2, 8'h00));
      @(negedge clk);
      vld[2] = 1'b1;
      dat[2] = 8'h00;
      for (int i = 0; i < 8; i++) begin
         n = 0;
         while (!rdy[2] && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (i > 0) begin
            checks++;
            if (dn[2] !== 1'b1) begin errors++; $display("FAIL b2b_done_at_accept%0d: tx_done=%b, expected 1", i, dn[2]); end
         end
         @(posedge clk);
         #1;
         if (i > 0) begin
            checks++;
            if (cyc - t_prev != 45) begin errors++; $display("FAIL b2b_period%0d: got %0d cycles, expected 45", i, cyc - t_prev); end
         end
         t_prev = cyc;
         if (i < 7) begin
            dat[2] = 8'(i + 1);
            sb.push_back(frame_of(2, 8'(i + 1)));
         end else
            vld[2] = 1'b0;
      end
      n = 0;
      while (!dn[2] && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      checks++; if (frames - f0 != 8) begin errors++; $display("FAIL b2b_frames: got %0d, expected 8", frames - f0); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_scoreboard: %0d pending, expected 0", sb.size()); end
   endtask

   task automatic test_hold_off;
      int n = 0, f0 = frames;
      mon_sel = 2;
      sb.push_back(frame_of(2, 8'h5A));
      @(negedge clk);
      vld[2] = 1'b1;
      dat[2] = 8'h5A;
      @(posedge clk);
      #1 vld[2] = 1'b0;
      repeat (10) @(negedge clk);
      dat[2] = 8'hFF;
      vld[2] = 1'b1;
      checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL holdoff_ready: got %b, expected 0", rdy[2]); end
      repeat (5) @(negedge clk);
      vld[2] = 1'b0;
      while (!dn[2] && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++; if (bsy[2] !== 1'b0) begin errors++; $display("FAIL holdoff_second_accept: busy=%b, expected 0", bsy[2]); end
      checks++; if (frames - f0 != 1) begin errors++; $display("FAIL holdoff_frames: got %0d, expected 1", frames - f0); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL holdoff_scoreboard: %0d pending, expected 0", sb.size()); end
   endtask

   task automatic test_reset_mid;
      int lat, n_done = 0;
      mon_sel = 2;
      sb.push_back(frame_of(2, 8'h3C));
      @(negedge clk);
      vld[2] = 1'b1;
      dat[2] = 8'h3C;
      @(posedge clk);
      #1 vld[2] = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      checks++; if (txl[2] !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx: got %b, expected 0", txl[2]); end
      abort = 1'b1;
      sys_rstn = 1'b0;
      #1;
      checks++; if (txl[2] !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b, expected 1", txl[2]); end
      checks++; if (rdy[2] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, expected 1", rdy[2]); end
      repeat (3) begin
         @(negedge clk);
         n_done += int'(dn[2]);
      end
      sys_rstn = 1'b1;
      repeat (60) begin
         @(negedge clk);
         n_done += int'(dn[2]);
      end
      checks++; if (n_done != 0) begin errors++; $display("FAIL rstmid_done: saw %0d done pulses, expected 0", n_done); end
      send(2, 8'h81, lat);
      checks++; if (lat != 44) begin errors++; $display("FAIL rstmid_next_latency: got %0d, expected 44", lat); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rstmid_scoreboard: %0d pending, expected 0", sb.size()); end
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_default();
      test_parity();
      test_data5();
      test_back_to_back();
      test_hold_off();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
